// File: rtl/fifo_serializer_pkg.sv
// fifo_serializer_pkg: shared types and helpers for the FIFO drain serializer.
// Holds the FSM state encoding and the beat slice offset function.
package fifo_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Bit offset of beat idx inside a wide entry.
  function automatic int unsigned beat_lsb(
    input int unsigned idx,
    input int unsigned w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// fifo_serializer_if: FIFO show-ahead read port plus val/rdy output stream.
// master = serializer side, slave = FIFO/consumer environment side.
interface fifo_serializer_if #(
  parameter int p_in_width  = 32,
  parameter int p_out_width = 8
);
  logic                   fifo_empty;
  logic [p_in_width-1:0]  fifo_rdata;
  logic                   fifo_pop;
  logic                   ostream_val;
  logic                   ostream_rdy;
  logic [p_out_width-1:0] ostream_msg;
  logic                   ostream_last;

  modport master (
    input  fifo_empty,
    input  fifo_rdata,
    input  ostream_rdy,
    output fifo_pop,
    output ostream_val,
    output ostream_msg,
    output ostream_last
  );

  modport slave (
    output fifo_empty,
    output fifo_rdata,
    output ostream_rdy,
    input  fifo_pop,
    input  ostream_val,
    input  ostream_msg,
    input  ostream_last
  );
endinterface

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops wide FIFO entries and emits them LSB beat first.
// Ports: clk, rst (sync, active-high), bus (fifo_serializer_if.master).
module fifo_serializer
  import fifo_serializer_pkg::*;
#(
  parameter int p_in_width  = 32,
  parameter int p_out_width = 8
) (
  input  logic               clk,
  input  logic               rst,
  fifo_serializer_if.master  bus
);

  localparam int NB = p_in_width / p_out_width;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  if ((p_in_width % p_out_width) != 0 || NB < 2) begin : g_bad_cfg
    $error("fifo_serializer: p_in_width must be a multiple >= 2 of p_out_width");
  end

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [p_in_width-1:0] data_q, data_d;
  logic                  pop;
  logic                  last;
  logic                  fire;

  assign last = (state_q == SEND) && (cnt_q == LAST);
  assign fire = (state_q == SEND) && bus.ostream_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          pop     = 1'b1;
          data_d  = bus.fifo_rdata;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fire) begin
          if (!last) begin
            cnt_d = cnt_q + CW'(1);
          end else if (!bus.fifo_empty) begin
            // back-to-back reload keeps one beat per cycle
            pop    = 1'b1;
            data_d = bus.fifo_rdata;
            cnt_d  = '0;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
    endcase
    // reset wins: the popped head would be lost otherwise
    if (rst) pop = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign bus.fifo_pop     = pop;
  assign bus.ostream_val  = (state_q == SEND);
  assign bus.ostream_last = last;
  assign bus.ostream_msg  =
    p_out_width'(data_q >> beat_lsb(32'(cnt_q), 32'(p_out_width)));

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed table, latency sequence and queue-model random
// runs for 32->8, 16->4 and 24->8 serializers behind a depth-2 FIFO model.
module tb_fifo_serializer;

  logic clk;
  logic rst;
  logic [2:0] empty_r;
  logic [2:0] rdy_r;
  logic [31:0] rd0;
  logic [15:0] rd1;
  logic [23:0] rd2;
  logic [1:0] sel;

  int checks;
  int errors;

  logic [31:0] fq[$];
  logic [8:0]  expq[$];

  typedef struct {
    logic        r;
    logic        push;
    logic [31:0] din;
    logic        rdy;
    logic        ep;
    logic        ev;
    logic        el;
    logic [7:0]  em;
    logic        cm;
  } vec_t;

  vec_t tbl[$];

  fifo_serializer_if #(.p_in_width(32), .p_out_width(8)) bus0 ();
  fifo_serializer_if #(.p_in_width(16), .p_out_width(4)) bus1 ();
  fifo_serializer_if #(.p_in_width(24), .p_out_width(8)) bus2 ();

  fifo_serializer #(.p_in_width(32), .p_out_width(8)) u0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  fifo_serializer #(.p_in_width(16), .p_out_width(4)) u1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  fifo_serializer #(.p_in_width(24), .p_out_width(8)) u2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus0.fifo_empty  = empty_r[0];
  assign bus1.fifo_empty  = empty_r[1];
  assign bus2.fifo_empty  = empty_r[2];
  assign bus0.fifo_rdata  = rd0;
  assign bus1.fifo_rdata  = rd1;
  assign bus2.fifo_rdata  = rd2;
  assign bus0.ostream_rdy = rdy_r[0];
  assign bus1.ostream_rdy = rdy_r[1];
  assign bus2.ostream_rdy = rdy_r[2];

  wire [2:0] pop_w;
  wire [2:0] val_w;
  wire [2:0] last_w;
  wire [7:0] msg0 = bus0.ostream_msg;
  wire [3:0] msg1 = bus1.ostream_msg;
  wire [7:0] msg2 = bus2.ostream_msg;

  assign pop_w[0]  = bus0.fifo_pop;
  assign pop_w[1]  = bus1.fifo_pop;
  assign pop_w[2]  = bus2.fifo_pop;
  assign val_w[0]  = bus0.ostream_val;
  assign val_w[1]  = bus1.ostream_val;
  assign val_w[2]  = bus2.ostream_val;
  assign last_w[0] = bus0.ostream_last;
  assign last_w[1] = bus1.ostream_last;
  assign last_w[2] = bus2.ostream_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic int iw(input logic [1:0] k);
    case (k)
      2'd0: return 32;
      2'd1: return 16;
      default: return 24;
    endcase
  endfunction

  function automatic int ow(input logic [1:0] k);
    case (k)
      2'd1: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] msg_of(input logic [1:0] k);
    case (k)
      2'd0: return msg0;
      2'd1: return {4'b0, msg1};
      default: return msg2;
    endcase
  endfunction

  function automatic void add(
    input int r, input int p, input logic [31:0] d, input int rdy,
    input int ep, input int ev, input int el, input logic [7:0] em,
    input int cm
  );
    vec_t v;
    v.r = r[0]; v.push = p[0]; v.din = d; v.rdy = rdy[0];
    v.ep = ep[0]; v.ev = ev[0]; v.el = el[0]; v.em = em; v.cm = cm[0];
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic set_rdata(input logic [31:0] w);
    case (sel)
      2'd0: rd0 = w;
      2'd1: rd1 = w[15:0];
      default: rd2 = w[23:0];
    endcase
  endtask

  // Inputs change 1 time unit after posedge; returns at the next negedge.
  task automatic drive(input logic r, input logic push,
                       input logic [31:0] din, input logic rdy);
    rst = r;
    if (push) fq.push_back(din);
    empty_r = 3'b111;
    empty_r[sel] = (fq.size() == 0);
    set_rdata(fq.size() != 0 ? fq[0] : 32'h0);
    rdy_r = 3'b000;
    rdy_r[sel] = rdy;
    @(negedge clk);
  endtask

  task automatic advance();
    logic p;
    p = pop_w[sel];
    @(posedge clk);
    #1;
    if (p && fq.size() != 0) void'(fq.pop_front());
  endtask

  function automatic logic [31:0] beat(input logic [31:0] w, input int j);
    return (w >> (j * ow(sel))) & ((32'd1 << ow(sel)) - 32'd1);
  endfunction

  // Scoreboard step for the random runs: beats enter at pop, leave at handshake.
  task automatic observe();
    int nb;
    logic [31:0] b;
    logic [8:0] e;
    nb = iw(sel) / ow(sel);
    if (pop_w[sel]) begin
      chk("pop_while_empty", 32'(empty_r[sel]), 32'd0);
      for (int j = 0; j < nb; j++) begin
        b = beat(fq.size() != 0 ? fq[0] : 32'h0, j);
        expq.push_back({(j == nb - 1), b[7:0]});
      end
    end
    if (val_w[sel] && rdy_r[sel]) begin
      if (expq.size() == 0) begin
        chk("spurious_beat", 32'(val_w[sel]), 32'd0);
      end else begin
        e = expq.pop_front();
        chk($sformatf("beat_k%0d", sel),
            32'({last_w[sel], msg_of(sel)}), 32'(e));
      end
    end
  endtask

  initial begin
    vec_t v;
    int n;
    logic [31:0] d;
    logic [31:0] w;
    logic push;
    logic rdy;

    checks = 0;
    errors = 0;
    sel = 2'd0;
    rst = 1'b1;
    empty_r = 3'b111;
    rdy_r = 3'b000;
    rd0 = '0;
    rd1 = '0;
    rd2 = '0;
    @(posedge clk);
    #1;

    // r  push din            rdy pop val last msg   cm
    add(1, 0, 32'h0,          1,  0,  0,  0,   8'h00, 1);
    add(1, 0, 32'h0,          1,  0,  0,  0,   8'h00, 1);
    add(1, 0, 32'h0,          1,  0,  0,  0,   8'h00, 1);
    add(0, 1, 32'hdeadbeef,   1,  1,  0,  0,   8'h00, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'hef, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'hbe, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'had, 1);
    add(0, 0, 32'h0,          1,  0,  1,  1,   8'hde, 1);
    add(0, 0, 32'h0,          1,  0,  0,  0,   8'h00, 0);
    add(0, 1, 32'hdeadbeef,   1,  1,  0,  0,   8'h00, 0);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'hef, 1);
    add(0, 0, 32'h0,          0,  0,  1,  0,   8'hbe, 1);
    add(0, 0, 32'h0,          0,  0,  1,  0,   8'hbe, 1);
    add(0, 0, 32'h0,          0,  0,  1,  0,   8'hbe, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'hbe, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'had, 1);
    add(0, 0, 32'h0,          1,  0,  1,  1,   8'hde, 1);
    add(0, 0, 32'h0,          1,  0,  0,  0,   8'h00, 0);
    add(0, 1, 32'h03020100,   1,  1,  0,  0,   8'h00, 0);
    add(0, 1, 32'h07060504,   1,  0,  1,  0,   8'h00, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h01, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h02, 1);
    add(0, 0, 32'h0,          1,  1,  1,  1,   8'h03, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h04, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h05, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h06, 1);
    add(0, 0, 32'h0,          1,  0,  1,  1,   8'h07, 1);
    add(0, 0, 32'h0,          1,  0,  0,  0,   8'h00, 0);
    add(0, 1, 32'h03020100,   1,  1,  0,  0,   8'h00, 0);
    add(0, 1, 32'h07060504,   1,  0,  1,  0,   8'h00, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h01, 1);
    add(1, 0, 32'h0,          1,  0,  1,  0,   8'h02, 1);
    add(1, 0, 32'h0,          1,  0,  0,  0,   8'h00, 1);
    add(0, 0, 32'h0,          1,  1,  0,  0,   8'h00, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h04, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h05, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h06, 1);
    add(0, 0, 32'h0,          1,  0,  1,  1,   8'h07, 1);
    add(0, 0, 32'h0,          1,  0,  0,  0,   8'h00, 0);
    add(0, 1, 32'h11223344,   1,  1,  0,  0,   8'h00, 0);
    add(0, 1, 32'h55667788,   1,  0,  1,  0,   8'h44, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h33, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h22, 1);
    add(0, 0, 32'h0,          0,  0,  1,  1,   8'h11, 1);
    add(0, 0, 32'h0,          0,  0,  1,  1,   8'h11, 1);
    add(0, 0, 32'h0,          1,  1,  1,  1,   8'h11, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h88, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h77, 1);
    add(0, 0, 32'h0,          1,  0,  1,  0,   8'h66, 1);
    add(0, 0, 32'h0,          1,  0,  1,  1,   8'h55, 1);
    add(0, 0, 32'h0,          1,  0,  0,  0,   8'h00, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      drive(v.r, v.push, v.din, v.rdy);
      chk($sformatf("row%0d.pop", i), 32'(pop_w[0]), 32'(v.ep));
      chk($sformatf("row%0d.val", i), 32'(val_w[0]), 32'(v.ev));
      chk($sformatf("row%0d.last", i), 32'(last_w[0]), 32'(v.el));
      if (v.cm) chk($sformatf("row%0d.msg", i), 32'(msg0), 32'(v.em));
      advance();
    end
    chk("fifo_empty_after_table", 32'(fq.size()), 32'd0);

    // Latency: entry at head in cycle t gives val in cycle t+1, then hold.
    d = 32'hcafef00d;
    drive(1'b0, 1'b1, d, 1'b0);
    chk("lat.pop", 32'(pop_w[0]), 32'd1);
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n = 0;
    while (!val_w[0] && n < 4) begin
      advance();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    chk("lat.cycles", 32'(n), 32'd0);
    for (int j = 0; j < 4; j++) begin
      advance();
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk($sformatf("lat.beat%0d", j), 32'(msg0), beat(d, j));
      chk($sformatf("lat.last%0d", j), 32'(last_w[0]), 32'(j == 3));
    end
    advance();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    chk("lat.idle", 32'(val_w[0]), 32'd0);
    advance();

    // Randomized runs against the queue scoreboard, all three geometries.
    for (int k = 0; k < 3; k++) begin
      sel = 2'(k);
      expq.delete();
      for (int c = 0; c < 200; c++) begin
        push = (fq.size() < 2) && ($urandom_range(1, 0) == 1);
        w = $urandom;
        w = w & 32'((64'd1 << iw(sel)) - 64'd1);
        rdy = ($urandom_range(3, 0) != 0);
        drive(1'b0, push, w, rdy);
        observe();
        advance();
      end
      n = 0;
      while ((expq.size() != 0 || fq.size() != 0) && n < 64) begin
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        observe();
        advance();
        n++;
      end
      chk($sformatf("drain_k%0d", k), 32'(expq.size()), 32'd0);
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      chk($sformatf("idle_k%0d", k), 32'(val_w[sel]), 32'd0);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
